// File: rtl/data_mem_responder.sv
// Fixed-latency load/store responder for the core's data port.
// Executes RV32I byte/half/word accesses on internal word storage.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_next_s;
    logic [CW-1:0] cnt_r;
    logic          req_ready_r;
    logic          rsp_valid_r;
    logic [31:0]   rdata_r;
    logic          err_r;

    logic          rd_r;
    logic          wr_r;
    logic [2:0]    f3_r;
    logic [AW+1:0] addr_r;
    logic [31:0]   wdata_r;

    logic          accept_s;
    logic          execute_s;
    logic          release_s;
    logic [AW-1:0] idx_s;
    logic [1:0]    lane_s;
    logic [31:0]   word_s;
    logic          err_s;
    logic [31:0]   load_s;
    logic [31:0]   store_s;
    logic          unused_addr_s;

    logic [31:0]   mem_r [DEPTH_WORDS];

    // Rejects misaligned, unlisted or ambiguous (read==write) requests.
    function automatic logic req_error(input logic rd, input logic wr,
                                       input logic [2:0] f3, input logic [1:0] lane);
        logic bad;
        if (rd == wr) begin
            bad = 1'b1;
        end else begin
            case (f3)
                3'b000:  bad = 1'b0;
                3'b001:  bad = lane[0];
                3'b010:  bad = (lane != 2'b00);
                3'b100:  bad = wr;
                3'b101:  bad = wr | lane[0];
                default: bad = 1'b1;
            endcase
        end
        return bad;
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [2:0] f3, input logic [1:0] lane);
        logic [31:0] sh;
        logic [31:0] res;
        sh = word >> {lane, 3'b000};
        case (f3)
            3'b000:  res = {{24{sh[7]}}, sh[7:0]};
            3'b001:  res = {{16{sh[15]}}, sh[15:0]};
            3'b010:  res = word;
            3'b100:  res = {24'h000000, sh[7:0]};
            3'b101:  res = {16'h0000, sh[15:0]};
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                                input logic [2:0] f3, input logic [1:0] lane);
        logic [31:0] res;
        res = old;
        case (f3)
            3'b000: begin
                for (int b = 0; b < 4; b++) begin
                    if (lane == 2'(b)) begin
                        res[8*b +: 8] = wd[7:0];
                    end
                end
            end
            3'b001: begin
                if (lane[1]) begin
                    res[31:16] = wd[15:0];
                end else begin
                    res[15:0] = wd[15:0];
                end
            end
            3'b010:  res = wd;
            default: res = old;
        endcase
        return res;
    endfunction

    assign unused_addr_s = ^addr[31:AW+2];

    assign idx_s   = addr_r[AW+1:2];
    assign lane_s  = addr_r[1:0];
    assign word_s  = mem_r[idx_s];
    assign err_s   = req_error(rd_r, wr_r, f3_r, lane_s);
    assign load_s  = load_extract(word_s, f3_r, lane_s);
    assign store_s = store_merge(word_s, wdata_r, f3_r, lane_s);

    // Next-state logic; execution fires on the WAIT->RESP transition.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        execute_s    = 1'b0;
        release_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_valid && req_ready_r) begin
                    accept_s     = 1'b1;
                    state_next_s = ST_WAIT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == '0) begin
                    execute_s    = 1'b1;
                    state_next_s = ST_RESP;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    release_s    = 1'b1;
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RESP;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Control state, request latch and registered response outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            req_ready_r <= 1'b0;
            rsp_valid_r <= 1'b0;
            rdata_r     <= 32'h0000_0000;
            err_r       <= 1'b0;
            rd_r        <= 1'b0;
            wr_r        <= 1'b0;
            f3_r        <= 3'b000;
            addr_r      <= '0;
            wdata_r     <= 32'h0000_0000;
        end else begin
            state_r     <= state_next_s;
            req_ready_r <= (state_next_s == ST_IDLE);
            if (accept_s) begin
                cnt_r   <= CNT_LOAD;
                rd_r    <= mem_read;
                wr_r    <= mem_write;
                f3_r    <= funct3;
                addr_r  <= addr[AW+1:0];
                wdata_r <= wdata;
            end else if (state_r == ST_WAIT && cnt_r != '0) begin
                cnt_r <= cnt_r - CW'(1);
            end
            if (execute_s) begin
                rsp_valid_r <= 1'b1;
                err_r       <= err_s;
                rdata_r     <= (err_s || wr_r) ? 32'h0000_0000 : load_s;
            end else if (release_s) begin
                rsp_valid_r <= 1'b0;
                err_r       <= 1'b0;
                rdata_r     <= 32'h0000_0000;
            end
        end
    end

    // Storage is deliberately not reset; only clean stores commit.
    always_ff @(posedge clk) begin
        if (execute_s && wr_r && !err_s) begin
            mem_r[idx_s] <= store_s;
        end
    end

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rdata     = rdata_r;
    assign err       = err_r;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder (DEPTH_WORDS=256, LATENCY=2).
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rdata;
    logic        err;

    int vectors = 0;
    int miscompares = 0;

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rdata     (rdata),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full request/response handshake, with optional response stall.
    task automatic do_req(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_rdata, input logic exp_err, input int stall);
        int n;
        n = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready"}, {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000;
        addr = 32'h0; wdata = 32'h0;
        check({tag, "_busy"}, {31'h0, req_ready}, 32'h0);
        @(posedge clk); #1;
        check({tag, "_early"}, {31'h0, rsp_valid}, 32'h0);
        @(posedge clk); #1;
        check({tag, "_valid"}, {31'h0, rsp_valid}, 32'h1);
        check({tag, "_rdata"}, rdata, exp_rdata);
        check({tag, "_err"}, {31'h0, err}, {31'h0, exp_err});
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, {31'h0, rsp_valid}, 32'h1);
            check({tag, "_hold_rdata"}, rdata, exp_rdata);
            check({tag, "_hold_ready"}, {31'h0, req_ready}, 32'h0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check({tag, "_done"}, {31'h0, rsp_valid}, 32'h0);
    endtask

    initial begin
        reset = 1'b0; req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        funct3 = 3'b000; addr = 32'h0; wdata = 32'h0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", {31'h0, req_ready}, 32'h0);
        check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_err", {31'h0, err}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rel_ready_before_edge", {31'h0, req_ready}, 32'h0);
        @(posedge clk); #1;
        check("rel_ready_after_edge", {31'h0, req_ready}, 32'h1);

        // 1: word store then load
        do_req("t1_sw", 1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 0);
        do_req("t1_lw", 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 0);

        // 2: byte store into lane 1, then sub-word loads
        do_req("t2_sb",  1'b0, 1'b1, 3'b000, 32'h11, 32'hFFFFFF7F, 32'h0, 1'b0, 0);
        do_req("t2_lb",  1'b1, 1'b0, 3'b000, 32'h11, 32'h0, 32'h0000007F, 1'b0, 0);
        do_req("t2_lbu", 1'b1, 1'b0, 3'b100, 32'h11, 32'h0, 32'h0000007F, 1'b0, 0);
        do_req("t2_lh",  1'b1, 1'b0, 3'b001, 32'h10, 32'h0, 32'h00007FEF, 1'b0, 0);
        do_req("t2_lhu", 1'b1, 1'b0, 3'b101, 32'h10, 32'h0, 32'h00007FEF, 1'b0, 0);
        do_req("t2_lw",  1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD7FEF, 1'b0, 0);

        // 3: sign versus zero extension
        do_req("t3_sw",  1'b0, 1'b1, 3'b010, 32'h20, 32'h00000080, 32'h0, 1'b0, 0);
        do_req("t3_lb",  1'b1, 1'b0, 3'b000, 32'h20, 32'h0, 32'hFFFFFF80, 1'b0, 0);
        do_req("t3_lbu", 1'b1, 1'b0, 3'b100, 32'h20, 32'h0, 32'h00000080, 1'b0, 0);
        do_req("t3_sh",  1'b0, 1'b1, 3'b001, 32'h22, 32'h0000ABCD, 32'h0, 1'b0, 0);
        do_req("t3_lh2", 1'b1, 1'b0, 3'b001, 32'h22, 32'h0, 32'hFFFFABCD, 1'b0, 0);
        do_req("t3_lw",  1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 32'hABCD0080, 1'b0, 0);

        // 4: rejected requests leave storage untouched
        do_req("t4_lw_mis",  1'b1, 1'b0, 3'b010, 32'h12, 32'h0, 32'h0, 1'b1, 0);
        do_req("t4_sh_mis",  1'b0, 1'b1, 3'b001, 32'h13, 32'h0000FFFF, 32'h0, 1'b1, 0);
        do_req("t4_f3_011",  1'b1, 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 0);
        do_req("t4_both",    1'b1, 1'b1, 3'b010, 32'h10, 32'h11111111, 32'h0, 1'b1, 0);
        do_req("t4_neither", 1'b0, 1'b0, 3'b010, 32'h10, 32'h22222222, 32'h0, 1'b1, 0);
        do_req("t4_sbu",     1'b0, 1'b1, 3'b100, 32'h10, 32'h33333333, 32'h0, 1'b1, 0);
        do_req("t4_lw",      1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD7FEF, 1'b0, 0);

        // 5: address aliasing and response stall
        do_req("t5_sw", 1'b0, 1'b1, 3'b010, 32'h404, 32'h12345678, 32'h0, 1'b0, 0);
        do_req("t5_lw", 1'b1, 1'b0, 3'b010, 32'h4, 32'h0, 32'h12345678, 1'b0, 5);

        // 6: reset during WAIT drops the in-flight store
        do_req("t6_init", 1'b0, 1'b1, 3'b010, 32'h30, 32'h0, 32'h0, 1'b0, 0);
        @(negedge clk);
        check("t6_ready", {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b1; funct3 = 3'b010;
        addr = 32'h30; wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        req_valid = 1'b0; mem_write = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("t6_rst_req_ready", {31'h0, req_ready}, 32'h0);
        check("t6_rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("t6_rst_rdata", rdata, 32'h0);
        check("t6_rst_err", {31'h0, err}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("t6_rst_hold_valid", {31'h0, rsp_valid}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("t6_rel_ready", {31'h0, req_ready}, 32'h1);
        do_req("t6_lw", 1'b1, 1'b0, 3'b010, 32'h30, 32'h0, 32'h0, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
